// File: rtl/db7_ssi_pkg.sv
// Shared types and frame constants for the DB7 SSI serial master.
// The optional read/write parity bit is enabled by defining DB7_SSI_PARITY_EN.
package db7_ssi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        STROBE,
        ACK
    } state_t;

    localparam int ADDR_BITS = 9;
    localparam int DATA_BITS = 16;

    // Bit counter covers the longest shift phase (16 data bits + parity).
    localparam int BIT_CNT_W = 5;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

    // Wide enough for 2 x ACK_TIMEOUT ticks with ACK_TIMEOUT up to 1023.
    localparam int ACK_CNT_W = 11;
    typedef logic [ACK_CNT_W-1:0] ack_cnt_t;

endpackage

// File: rtl/ssi_tick_gen.sv
// Divider producing a one-cycle tick every CLK_DIV PCI_Clock cycles while enabled.
// A restart pulse realigns the phase so the first tick lands CLK_DIV cycles later.
module ssi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic PCI_Clock,
    input  logic PCI_Reset,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_reg;

    always_ff @(posedge PCI_Clock or negedge PCI_Reset) begin
        if (!PCI_Reset) begin
            div_cnt_reg <= '0;
        end else if (restart) begin
            div_cnt_reg <= '0;
        end else if (enable) begin
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? 8'd0 : div_cnt_reg + 8'd1;
        end
    end

    assign tick = enable && !restart && (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/db7_ssi_master.sv
// DB7 SSI master: serialises one register transfer per start pulse and waits for SSAck.
// Define DB7_SSI_PARITY_EN to append an even-parity bit to the data phase.
module db7_ssi_master
    import db7_ssi_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        PCI_Clock,
    input  logic        PCI_Reset,
    input  logic        start,
    input  logic        rd_nwr,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        no_response,
    output logic        parity_err,
    output logic        SSClock,
    output logic        SSAddr,
    output logic        SSDOut,
    output logic        SSStrobe,
    input  logic        SSAck
);

`ifdef DB7_SSI_PARITY_EN
    localparam int FRAME_DATA_BITS = DATA_BITS + 1;
`else
    localparam int FRAME_DATA_BITS = DATA_BITS;
`endif

    localparam bit_cnt_t ADDR_LAST   = BIT_CNT_W'(ADDR_BITS - 1);
    localparam bit_cnt_t DATA_LAST   = BIT_CNT_W'(FRAME_DATA_BITS - 1);
    localparam bit_cnt_t STROBE_LAST = BIT_CNT_W'(2);
    localparam ack_cnt_t ACK_LAST    = ACK_CNT_W'(2 * ACK_TIMEOUT - 1);

    state_t                       state_reg,   state_next;
    logic                         phase_reg,   phase_next;
    bit_cnt_t                     bit_cnt_reg, bit_cnt_next;
    ack_cnt_t                     ack_cnt_reg, ack_cnt_next;
    logic                         rd_reg,      rd_next;
    logic [ADDR_BITS-1:0]         addr_sh_reg, addr_sh_next;
    logic [FRAME_DATA_BITS-1:0]   tx_sh_reg,   tx_sh_next;
    logic [DATA_BITS-1:0]         rx_reg,      rx_next;
    logic [DATA_BITS-1:0]         rdata_reg,   rdata_next;
    logic                         ready_reg,   ready_next;
    logic                         no_resp_reg, no_resp_next;
    logic                         sclk_reg,    sclk_next;
    logic                         ssaddr_reg,  ssaddr_next;
    logic                         ssdout_reg,  ssdout_next;
    logic                         strobe_reg,  strobe_next;
`ifdef DB7_SSI_PARITY_EN
    logic                         rx_par_reg,  rx_par_next;
    logic                         par_err_reg, par_err_next;
`endif

    logic ack_meta_reg, ack_sync_reg;
    logic accept;
    logic tick;

    assign accept = (state_reg == IDLE) && start && ready_reg;

    ssi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .PCI_Clock (PCI_Clock),
        .PCI_Reset (PCI_Reset),
        .restart   (accept),
        .enable    (state_reg != IDLE),
        .tick      (tick)
    );

    // SSAck comes from the slave with no clock relationship to PCI_Clock.
    always_ff @(posedge PCI_Clock or negedge PCI_Reset) begin
        if (!PCI_Reset) begin
            ack_meta_reg <= 1'b0;
            ack_sync_reg <= 1'b0;
        end else begin
            ack_meta_reg <= SSAck;
            ack_sync_reg <= ack_meta_reg;
        end
    end

    always_ff @(posedge PCI_Clock or negedge PCI_Reset) begin
        if (!PCI_Reset) begin
            state_reg   <= IDLE;
            phase_reg   <= 1'b0;
            bit_cnt_reg <= '0;
            ack_cnt_reg <= '0;
            rd_reg      <= 1'b0;
            addr_sh_reg <= '0;
            tx_sh_reg   <= '0;
            rx_reg      <= '0;
            rdata_reg   <= '0;
            ready_reg   <= 1'b1;
            no_resp_reg <= 1'b0;
            sclk_reg    <= 1'b0;
            ssaddr_reg  <= 1'b0;
            ssdout_reg  <= 1'b0;
            strobe_reg  <= 1'b0;
`ifdef DB7_SSI_PARITY_EN
            rx_par_reg  <= 1'b0;
            par_err_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            bit_cnt_reg <= bit_cnt_next;
            ack_cnt_reg <= ack_cnt_next;
            rd_reg      <= rd_next;
            addr_sh_reg <= addr_sh_next;
            tx_sh_reg   <= tx_sh_next;
            rx_reg      <= rx_next;
            rdata_reg   <= rdata_next;
            ready_reg   <= ready_next;
            no_resp_reg <= no_resp_next;
            sclk_reg    <= sclk_next;
            ssaddr_reg  <= ssaddr_next;
            ssdout_reg  <= ssdout_next;
            strobe_reg  <= strobe_next;
`ifdef DB7_SSI_PARITY_EN
            rx_par_reg  <= rx_par_next;
            par_err_reg <= par_err_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        bit_cnt_next = bit_cnt_reg;
        ack_cnt_next = ack_cnt_reg;
        rd_next      = rd_reg;
        addr_sh_next = addr_sh_reg;
        tx_sh_next   = tx_sh_reg;
        rx_next      = rx_reg;
        rdata_next   = rdata_reg;
        ready_next   = ready_reg;
        no_resp_next = no_resp_reg;
        sclk_next    = sclk_reg;
        ssaddr_next  = ssaddr_reg;
        ssdout_next  = ssdout_reg;
        strobe_next  = strobe_reg;
`ifdef DB7_SSI_PARITY_EN
        rx_par_next  = rx_par_reg;
        par_err_next = par_err_reg;
`endif

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    rd_next      = rd_nwr;
                    addr_sh_next = {addr, rd_nwr};
`ifdef DB7_SSI_PARITY_EN
                    tx_sh_next   = {wdata, ^wdata};
                    par_err_next = 1'b0;
`else
                    tx_sh_next   = wdata;
`endif
                    no_resp_next = 1'b0;
                    ready_next   = 1'b0;
                    phase_next   = 1'b0;
                    bit_cnt_next = '0;
                    state_next   = ADDR;
                end
            end

            ADDR: begin
                if (tick) begin
                    if (!phase_reg) begin
                        sclk_next    = 1'b0;
                        ssaddr_next  = addr_sh_reg[ADDR_BITS-1];
                        ssdout_next  = 1'b0;
                        addr_sh_next = {addr_sh_reg[ADDR_BITS-2:0], 1'b0};
                        phase_next   = 1'b1;
                    end else begin
                        sclk_next  = 1'b1;
                        phase_next = 1'b0;
                        if (bit_cnt_reg == ADDR_LAST) begin
                            bit_cnt_next = '0;
                            state_next   = DATA;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (!phase_reg) begin
                        sclk_next   = 1'b0;
                        ssaddr_next = 1'b0;
                        ssdout_next = rd_reg ? 1'b0 : tx_sh_reg[FRAME_DATA_BITS-1];
                        tx_sh_next  = {tx_sh_reg[FRAME_DATA_BITS-2:0], 1'b0};
                        phase_next  = 1'b1;
                    end else begin
                        sclk_next  = 1'b1;
                        phase_next = 1'b0;
                        // Read data is captured on the rising SSClock tick, MSB first.
                        if (rd_reg) begin
`ifdef DB7_SSI_PARITY_EN
                            if (bit_cnt_reg == DATA_LAST) begin
                                rx_par_next = ack_sync_reg;
                            end else begin
                                rx_next = {rx_reg[DATA_BITS-2:0], ack_sync_reg};
                            end
`else
                            rx_next = {rx_reg[DATA_BITS-2:0], ack_sync_reg};
`endif
                        end
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_next = '0;
                            state_next   = STROBE;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
            end

            STROBE: begin
                // Strobe rises on the first tick and drops two ticks later: one SSClock period.
                if (tick) begin
                    if (bit_cnt_reg == '0) begin
                        sclk_next    = 1'b0;
                        ssdout_next  = 1'b0;
                        strobe_next  = 1'b1;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end else if (bit_cnt_reg == STROBE_LAST) begin
                        strobe_next  = 1'b0;
                        bit_cnt_next = '0;
                        ack_cnt_next = '0;
                        state_next   = ACK;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

            ACK: begin
                // An ack seen on the expiring tick still wins over the timeout.
                if (tick) begin
                    if (ack_sync_reg) begin
                        if (rd_reg) begin
                            rdata_next = rx_reg;
`ifdef DB7_SSI_PARITY_EN
                            par_err_next = (rx_par_reg != ^rx_reg);
`endif
                        end
                        ready_next = 1'b1;
                        state_next = IDLE;
                    end else if (ack_cnt_reg == ACK_LAST) begin
                        no_resp_next = 1'b1;
                        ready_next   = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        ack_cnt_next = ack_cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rdata       = rdata_reg;
    assign ready       = ready_reg;
    assign no_response = no_resp_reg;
    assign SSClock     = sclk_reg;
    assign SSAddr      = ssaddr_reg;
    assign SSDOut      = ssdout_reg;
    assign SSStrobe    = strobe_reg;
`ifdef DB7_SSI_PARITY_EN
    assign parity_err  = par_err_reg;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_db7_ssi_master.sv
// Scoreboard bench for db7_ssi_master with a behavioural SSI slave.
// Build with DB7_SSI_PARITY_EN defined to exercise the parity bit.
`timescale 1ns/1ps
module tb_db7_ssi_master;

    localparam int CLK_DIV     = 4;
    localparam int ACK_TIMEOUT = 64;
`ifdef DB7_SSI_PARITY_EN
    localparam int DL = 17;
`else
    localparam int DL = 16;
`endif

    logic        PCI_Clock = 1'b0;
    logic        PCI_Reset = 1'b0;
    logic        start     = 1'b0;
    logic        rd_nwr    = 1'b0;
    logic [7:0]  addr      = 8'h00;
    logic [15:0] wdata     = 16'h0000;
    logic [15:0] rdata;
    logic        ready, no_response, parity_err;
    logic        SSClock, SSAddr, SSDOut, SSStrobe;
    logic        SSAck;

    db7_ssi_master #(
        .CLK_DIV     (CLK_DIV),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .PCI_Clock   (PCI_Clock),
        .PCI_Reset   (PCI_Reset),
        .start       (start),
        .rd_nwr      (rd_nwr),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .no_response (no_response),
        .parity_err  (parity_err),
        .SSClock     (SSClock),
        .SSAddr      (SSAddr),
        .SSDOut      (SSDOut),
        .SSStrobe    (SSStrobe),
        .SSAck       (SSAck)
    );

    always #5 PCI_Clock = ~PCI_Clock;

    typedef struct {
        logic [8:0]  addr_seq;
        logic [16:0] dout_seq;
        logic [15:0] rdata;
        logic        nr;
        logic        pe;
        int          ack_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave configuration, written only by the stimulus process.
    logic        cfg_read  = 1'b0;
    logic [16:0] cfg_resp  = '0;
    int          cfg_delay = -1;

    // Slave/monitor state, written only by the slave process.
    logic        prev_sclk, prev_strobe, prev_ready, in_ack, sclk_in_strobe;
    int          bit_idx, strobe_len, ack_cyc;
    logic [8:0]  cap_addr;
    logic [16:0] cap_dout;

    always @(negedge PCI_Clock or negedge PCI_Reset) begin
        if (!PCI_Reset) begin
            SSAck = 1'b0; prev_sclk = 1'b0; prev_strobe = 1'b0; prev_ready = 1'b1;
            in_ack = 1'b0; sclk_in_strobe = 1'b0; bit_idx = 0; strobe_len = 0; ack_cyc = 0;
            cap_addr = '0; cap_dout = '0;
        end else begin
            if (prev_ready && !ready) begin
                bit_idx = 0; strobe_len = 0; sclk_in_strobe = 1'b0; cap_addr = '0; cap_dout = '0;
            end
            if (SSClock && !prev_sclk) begin
                if (bit_idx < 9) cap_addr = {cap_addr[7:0], SSAddr};
                else             cap_dout = {cap_dout[15:0], SSDOut};
                bit_idx++;
            end
            if (!SSClock && prev_sclk) begin
                if (cfg_read && bit_idx >= 9 && bit_idx < 9 + DL) SSAck = cfg_resp[DL-1-(bit_idx-9)];
                else SSAck = 1'b0;
            end
            if (SSStrobe) begin
                strobe_len++;
                if (SSClock) sclk_in_strobe = 1'b1;
            end
            if (in_ack) begin
                if (ready) begin
                    in_ack = 1'b0;
                    SSAck  = 1'b0;
                end else begin
                    ack_cyc++;
                    if (cfg_delay >= 0 && ack_cyc >= cfg_delay * CLK_DIV) SSAck = 1'b1;
                end
            end
            if (!SSStrobe && prev_strobe) begin
                in_ack  = 1'b1;
                ack_cyc = 0;
            end
            prev_sclk   = SSClock;
            prev_strobe = SSStrobe;
            prev_ready  = ready;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rdata"},  rdata,       0);
        check_val({tag, "_ready"},  ready,       1);
        check_val({tag, "_nr"},     no_response, 0);
        check_val({tag, "_pe"},     parity_err,  0);
        check_val({tag, "_sclk"},   SSClock,     0);
        check_val({tag, "_saddr"},  SSAddr,      0);
        check_val({tag, "_sdout"},  SSDOut,      0);
        check_val({tag, "_strobe"}, SSStrobe,    0);
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (ready !== 1'b1 && guard < 3000) begin
            @(negedge PCI_Clock);
            guard++;
        end
        check_val({tag, "_done"}, ready, 1);
    endtask

    task automatic do_xfer(input logic rd, input logic [7:0] a, input logic [15:0] wd,
                           input logic [15:0] resp_word, input logic resp_par, input int delay,
                           input logic [15:0] exp_rd, input logic exp_pe, input logic inject);
        exp_t e;
        e.addr_seq = {a, rd};
        e.dout_seq = rd ? 17'd0 : ((DL == 17) ? {wd, ^wd} : {1'b0, wd});
        e.rdata    = exp_rd;
        e.nr       = (delay < 0);
        e.pe       = exp_pe;
        e.ack_cyc  = (delay < 0) ? 2 * ACK_TIMEOUT * CLK_DIV - 1 : -1;
        sb_q.push_back(e);
        cfg_read  = rd;
        cfg_resp  = (DL == 17) ? {resp_word, resp_par} : {1'b0, resp_word};
        cfg_delay = delay;

        @(negedge PCI_Clock);
        start = 1'b1; rd_nwr = rd; addr = a; wdata = wd;
        @(negedge PCI_Clock);
        start = 1'b0; rd_nwr = ~rd; addr = ~a; wdata = ~wd;
        check_val("ready_fall", ready, 0);
        check_val("nr_clear", no_response, 0);
        check_val("pe_clear", parity_err, 0);
        if (inject) begin
            repeat (120) @(negedge PCI_Clock);
            start = 1'b1; rd_nwr = ~rd; addr = 8'h3C; wdata = 16'hFFFF;
            @(negedge PCI_Clock);
            start = 1'b0;
        end
        wait_ready("xfer");
        @(posedge PCI_Clock);
        #1;
        e = sb_q.pop_front();
        check_val("rdata",      rdata,          e.rdata);
        check_val("no_resp",    no_response,    e.nr);
        check_val("parity_err", parity_err,     e.pe);
        check_val("addr_seq",   cap_addr,       e.addr_seq);
        check_val("dout_seq",   cap_dout,       e.dout_seq);
        check_val("bit_count",  bit_idx,        9 + DL);
        check_val("strobe_len", strobe_len,     2 * CLK_DIV);
        check_val("sclk_strobe", sclk_in_strobe, 0);
        if (e.ack_cyc >= 0) check_val("ack_timeout_cyc", ack_cyc, e.ack_cyc);
        $display("xfer rd=%0d addr=%02h wdata=%04h rdata=%04h no_resp=%0d parity_err=%0d",
                 rd, a, wd, rdata, no_response, parity_err);
    endtask

    initial begin
        repeat (4) @(negedge PCI_Clock);
        check_reset_outputs("rst");
        PCI_Reset = 1'b1;
        repeat (2) @(negedge PCI_Clock);

        do_xfer(1'b0, 8'hA5, 16'h1234, 16'h0000, 1'b0, 3, 16'h0000, 1'b0, 1'b0);
        do_xfer(1'b1, 8'h10, 16'h0000, 16'hBEEF, ^16'hBEEF, 1, 16'hBEEF, 1'b0, 1'b0);
        do_xfer(1'b1, 8'h22, 16'h0000, 16'h1357, 1'b0, -1, 16'hBEEF, 1'b0, 1'b0);
        do_xfer(1'b0, 8'h5A, 16'hC3C3, 16'h0000, 1'b0, 0, 16'hBEEF, 1'b0, 1'b1);
        do_xfer(1'b1, 8'hE1, 16'h0000, 16'h8001, ^16'h8001, 2, 16'h8001, 1'b0, 1'b0);

        // Reset in the middle of a write's data phase.
        cfg_read = 1'b0; cfg_delay = -1;
        @(negedge PCI_Clock);
        start = 1'b1; rd_nwr = 1'b0; addr = 8'h77; wdata = 16'hAAAA;
        @(negedge PCI_Clock);
        start = 1'b0;
        repeat (120) @(negedge PCI_Clock);
        check_val("pre_rst_busy", ready, 0);
        PCI_Reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        $display("xfer reset asserted mid-frame");
        repeat (3) @(negedge PCI_Clock);
        PCI_Reset = 1'b1;
        repeat (2) @(negedge PCI_Clock);

        do_xfer(1'b0, 8'h81, 16'h5555, 16'h0000, 1'b0, 2, 16'h0000, 1'b0, 1'b0);

`ifdef DB7_SSI_PARITY_EN
        do_xfer(1'b0, 8'h01, 16'h0001, 16'h0000, 1'b0, 1, 16'h0000, 1'b0, 1'b0);
        check_val("par_bit_write", cap_dout[0], 1);
        do_xfer(1'b1, 8'h02, 16'h0000, 16'h0003, 1'b1, 1, 16'h0003, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/db7_ssi_master.md
# db7_ssi_master

Serial master for the DB7 Synchronous Serial Interface (SSI), directly downstream of the PCI I/O decode in the DC7 card. It takes a one-cycle transfer request (address, direction, 16-bit word) from the x86 register logic. It serialises the request onto SSClock/SSAddr/SSDOut/SSStrobe, then waits for SSAck. It returns read data, a ready flag and a no-response flag that the x86 status register reports.

## Interface
- CLK_DIV, 4: PCI_Clock cycles per SSClock half-period; legal range 2..255.
- ACK_TIMEOUT, 64: SSClock periods to wait for SSAck before flagging no response; legal range 1..1023.

Ports:
- PCI_Clock  in  1  sole clock.
- PCI_Reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse; honoured only when ready=1.
- rd_nwr  in  1  1 = read, 0 = write; sampled with start.
- addr  in  8  DB7 register address; sampled with start.
- wdata  in  16  write word; sampled with start.
- rdata  out  16  last successfully read word.
- ready  out  1  high when idle.
- no_response  out  1  last transfer timed out waiting for SSAck.
- parity_err  out  1  read parity mismatch; see Configuration.
- SSClock  out  1  serial clock.
- SSAddr  out  1  address/command line.
- SSDOut  out  1  serial write data.
- SSStrobe  out  1  end-of-frame strobe.
- SSAck  in  1  asynchronous acknowledge and serial read-data return.

## Operation
- Reset values:
  - rdata=0, ready=1, no_response=0, parity_err=0.
  - SSClock=0, SSAddr=0, SSDOut=0, SSStrobe=0.
  - State IDLE; all counters 0.
- SSAck passes through a 2-flop synchroniser. All uses of SSAck are the synchronised value.
- Tick: an internal divider pulses every CLK_DIV cycles. It runs only outside IDLE and restarts at 0 on an accepted start.
- State machine (states advance on ticks):
  - IDLE: on start with ready=1, latch rd_nwr/addr/wdata, clear no_response and parity_err, drop ready, go to ADDR. A start while ready=0 is ignored, with no side effects.
  - ADDR: 9 bits, MSB first: addr[7:0], then rd_nwr. SSAddr carries the bit; SSDOut=0.
  - DATA: 16 bits, MSB first, SSAddr=0.
    - Write: SSDOut carries wdata.
    - Read: SSDOut=0; SSAck is shifted in on each SSClock rising tick.
  - STROBE: SSStrobe=1 for one full SSClock period; SSClock held 0.
  - ACK: SSClock held 0. SSAck is checked on every tick:
    - SSAck=1: commit the read word to rdata (reads only), set ready, go to IDLE.
    - No SSAck after ACK_TIMEOUT×2 ticks: set no_response, set ready, go to IDLE. rdata is left unchanged.
- Bit framing: each bit spans two ticks. SSClock goes low and the new bit is driven on the first tick; SSClock rises on the second tick.
- Boundary conditions:
  - SSAck high before ACK is entered is ignored.
  - An ACK tick that sees SSAck=1 on the same tick the timeout expires counts as an ack.
  - Reset asserted mid-frame forces reset values immediately. No partial rdata update.

## Timing
- ready falls the cycle after an accepted start.
- Bit period is 2×CLK_DIV cycles.
- Frame length: 9 address bits + 16 data bits (+1 parity bit if enabled), plus 1 strobe period.
  - With defaults and an immediate ack, the frame is 26 bit periods = 208 cycles, plus 1–2 ticks of ack latency, plus 2 cycles of synchroniser delay.
- SSAck sampling latency is 2 PCI_Clock cycles (synchroniser).
- rdata, ready and no_response update together, in the same cycle.

## Configuration
- DB7_SSI_PARITY_EN defined:
  - One even-parity bit follows the 16 data bits in DATA.
  - Write: the parity of wdata is driven on SSDOut.
  - Read: the parity bit is sampled from SSAck. On mismatch, parity_err=1 at completion and rdata still updates.
- Not defined: DATA is 16 bits and parity_err is tied to 0.

## Structure
- Package db7_ssi_pkg:
  - State enum: IDLE, ADDR, DATA, STROBE, ACK.
  - Constants: ADDR_BITS=9, DATA_BITS=16.
  - Type for the ack timeout counter width.
- One sub-module, ssi_tick_gen: CLK_DIV divider with synchronous restart and tick output.

## Test plan
- Write, addr=0xA5, wdata=0x1234, SSAck asserted 3 ticks into ACK:
  - SSAddr sequence is 1,0,1,0,0,1,0,1,0.
  - SSDOut sequence is 0x1234, MSB first.
  - One SSStrobe period; ready returns; no_response=0.
- Read, addr=0x10, slave drives 0xBEEF on SSAck then acks → rdata=0xBEEF, no_response=0.
- Read with SSAck never asserted → no_response=1 after ACK_TIMEOUT×2 ticks in ACK; rdata keeps its prior value; next start clears no_response.
- start pulsed during DATA with different addr/wdata → ignored; frame completes with the original values.
- PCI_Reset low midway through DATA → all outputs at reset values immediately; after release, a fresh write completes normally.
- With DB7_SSI_PARITY_EN:
  - Write 0x0001 → 17th data bit = 1.
  - Read 0x0003 with slave parity bit 1 → parity_err=1, rdata=0x0003.
